// File: rtl/mdu_sched_if.sv
// mdu_sched_if: E/D-stage request signals and multiply/divide datapath
// control signals for the MD issue/sequencing controller.
//   e_md_valid, e_md_op[2:0], e_div_zero  E-stage MD instruction and operand info
//   d_md_use                              D-stage holds an MD-class instruction
//   abort                                 synchronous cancel of the in-flight op
//   md_start, md_op[1:0]                  start pulse and op code to the datapath
//   busy, stall                           occupancy and F/D freeze
//   hi_we, lo_we, wb_src, rd_sel_hi       HI/LO write enables and mux selects
//   proto_err                             sticky protocol-violation flag
// The slave modport is the controller; the master modport is the pipeline side.
interface mdu_sched_if;
  logic       e_md_valid;
  logic [2:0] e_md_op;
  logic       e_div_zero;
  logic       d_md_use;
  logic       abort;
  logic       md_start;
  logic [1:0] md_op;
  logic       busy;
  logic       stall;
  logic       hi_we;
  logic       lo_we;
  logic       wb_src;
  logic       rd_sel_hi;
  logic       proto_err;

  modport slave (
    input  e_md_valid, e_md_op, e_div_zero, d_md_use, abort,
    output md_start, md_op, busy, stall, hi_we, lo_we, wb_src, rd_sel_hi, proto_err
  );

  modport master (
    output e_md_valid, e_md_op, e_div_zero, d_md_use, abort,
    input  md_start, md_op, busy, stall, hi_we, lo_we, wb_src, rd_sel_hi, proto_err
  );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: issue/sequencing controller for the HI/LO multiply/divide unit.
// Decodes the E-stage MD op, pulses md_start, counts a fixed unit latency,
// commits HI/LO in the last busy cycle and stalls D-stage MD instructions
// while the unit is occupied.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mdu_sched_if.slave (see interface header for signal list)
// Parameters: MULT_CYC / DIV_CYC busy cycles (1..2^CNT_W-1), CNT_W counter width.
module mdu_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  mdu_sched_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             nz_r;
  logic             proto_err_r;

  logic             run_s;
  logic             md_start_s;
  logic             commit_s;
  logic             mt_ok_s;
  logic             hi_we_s;
  logic             lo_we_s;
  logic             wb_src_s;

  // Issue decode and HI/LO write-enable / source selection
  always_comb begin
    run_s      = (state_r == ST_RUN);
    md_start_s = bus.e_md_valid & ~bus.e_md_op[2] & ~run_s & ~bus.abort;
    // abort squashes the commit even when it lands on the last busy cycle
    commit_s   = run_s & (cnt_r == CNT_W'(1)) & ~bus.abort;
    mt_ok_s    = bus.e_md_valid & ~run_s & ~bus.abort;
    hi_we_s    = 1'b0;
    lo_we_s    = 1'b0;
    wb_src_s   = 1'b0;
    if (commit_s) begin
      // nz_r low means divide-by-zero: run the full latency, keep old HI/LO
      hi_we_s  = nz_r;
      lo_we_s  = nz_r;
      wb_src_s = 1'b1;
    end else if (mt_ok_s && (bus.e_md_op == 3'b110)) begin
      hi_we_s  = 1'b1;
    end else if (mt_ok_s && (bus.e_md_op == 3'b111)) begin
      lo_we_s  = 1'b1;
    end else begin
      hi_we_s  = 1'b0;
      lo_we_s  = 1'b0;
    end
  end

  assign bus.md_start  = md_start_s;
  assign bus.md_op     = bus.e_md_op[1:0];
  assign bus.busy      = run_s;
  assign bus.stall     = bus.d_md_use & (run_s | md_start_s);
  assign bus.hi_we     = hi_we_s;
  assign bus.lo_we     = lo_we_s;
  assign bus.wb_src    = wb_src_s;
  assign bus.rd_sel_hi = (bus.e_md_op == 3'b100);
  assign bus.proto_err = proto_err_r;

  // Sticky flag: any MD op presented in E while the unit is still running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err_r <= 1'b0;
    end else if (run_s && bus.e_md_valid) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  // IDLE/RUN sequencing with latency countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      nz_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (md_start_s) begin
            state_r <= ST_RUN;
            cnt_r   <= bus.e_md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            nz_r    <= ~(bus.e_div_zero & bus.e_md_op[1]);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // cnt_r==0 in RUN is unreachable; treated as completion to recover
          if (bus.abort || (cnt_r < CNT_W'(2))) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            nz_r    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          nz_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed-vector bench for mdu_sched with a scoreboard.
// Each stimulus cycle pushes its hand-computed expected outputs into a
// queue; an independent monitor pops and compares on every falling edge.
module tb_mdu_sched;

  // Expected flag layout: {md_start, busy, stall, hi_we, lo_we, wb_src, rd_sel_hi, proto_err}
  localparam logic [7:0] F_ST = 8'b1000_0000;
  localparam logic [7:0] F_BZ = 8'b0100_0000;
  localparam logic [7:0] F_SL = 8'b0010_0000;
  localparam logic [7:0] F_HW = 8'b0001_0000;
  localparam logic [7:0] F_LW = 8'b0000_1000;
  localparam logic [7:0] F_WB = 8'b0000_0100;
  localparam logic [7:0] F_RS = 8'b0000_0010;
  localparam logic [7:0] F_PE = 8'b0000_0001;
  localparam logic [7:0] F_0  = 8'b0000_0000;

  typedef struct packed {
    logic [15:0] id;
    logic [1:0]  op;
    logic [7:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_sched_if bus();

  mdu_sched #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t        sb_q[$];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          next_id  = 0;
  exp_t        cur;
  logic [7:0]  act_f;

  // Apply one cycle of inputs and record the expected outputs for it
  task automatic cyc(input logic rst, input logic v, input logic [2:0] op,
                     input logic dz, input logic du, input logic ab,
                     input logic [7:0] f);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.e_md_valid = v;
    bus.e_md_op    = op;
    bus.e_div_zero = dz;
    bus.d_md_use   = du;
    bus.abort      = ab;
    e.id = 16'(next_id);
    e.op = op[1:0];
    e.f  = f;
    next_id++;
    sb_q.push_back(e);
  endtask

  // n cycles with no E-stage op
  task automatic quiet(input int n, input logic du, input logic [7:0] f);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'b000, 1'b0, du, 1'b0, f);
  endtask

  // Monitor: compare DUT outputs against the scoreboard head each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        cur   = sb_q.pop_front();
        act_f = {bus.md_start, bus.busy, bus.stall, bus.hi_we, bus.lo_we,
                 bus.wb_src, bus.rd_sel_hi, bus.proto_err};
        vec_cnt++;
        if ((act_f !== cur.f) || (bus.md_op !== cur.op)) begin
          miss_cnt++;
          $display("FAIL vec%0d: got md_op=%b flags=%b, expected md_op=%b flags=%b (start,busy,stall,hi_we,lo_we,wb_src,rd_sel_hi,proto_err)",
                   cur.id, bus.md_op, act_f, cur.op, cur.f);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.e_md_valid = 1'b0;
    bus.e_md_op    = 3'b000;
    bus.e_div_zero = 1'b0;
    bus.d_md_use   = 1'b0;
    bus.abort      = 1'b0;

    // reset state
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, F_0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, F_0);
    quiet(1, 1'b0, F_0);

    // mult with D-stage MD use T..T+8, mfhi enters E at T+6
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, F_ST | F_SL);
    quiet(4, 1'b1, F_BZ | F_SL);
    quiet(1, 1'b1, F_BZ | F_SL | F_HW | F_LW | F_WB);
    cyc(1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, F_RS);
    quiet(2, 1'b1, F_0);

    // divu, nonzero divisor: commit at T+10
    cyc(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, F_ST);
    quiet(9, 1'b0, F_BZ);
    quiet(1, 1'b0, F_BZ | F_HW | F_LW | F_WB);
    // back-to-back: divu by zero right after commit, full latency, no write
    cyc(1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, F_ST);
    quiet(9, 1'b0, F_BZ);
    quiet(1, 1'b0, F_BZ | F_WB);
    quiet(1, 1'b0, F_0);

    // mthi / mtlo / mflo in IDLE, then mthi blocked by abort
    cyc(1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, F_HW);
    cyc(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, F_LW);
    cyc(1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, F_0);
    cyc(1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, F_0);

    // div aborted at T+3: idle from T+4, nothing written through T+12
    cyc(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, F_ST);
    quiet(2, 1'b0, F_BZ);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, F_BZ);
    quiet(9, 1'b0, F_0);

    // mult aborted exactly in its commit cycle
    cyc(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, F_ST);
    quiet(4, 1'b0, F_BZ);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, F_BZ);
    quiet(1, 1'b0, F_0);

    // start and abort together: no start, no stall, stays idle
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, F_0);
    quiet(1, 1'b1, F_0);

    // mult (div_zero ignored) with MD op forced in at T+2: proto_err sticky
    cyc(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, F_ST);
    quiet(1, 1'b0, F_BZ);
    cyc(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, F_BZ);
    quiet(2, 1'b0, F_BZ | F_PE);
    quiet(1, 1'b0, F_BZ | F_HW | F_LW | F_WB | F_PE);
    quiet(1, 1'b0, F_PE);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, F_0);
    quiet(1, 1'b0, F_0);

    // reset mid-run at T+3: immediate idle, no later commit
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, F_ST);
    quiet(2, 1'b0, F_BZ);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, F_0);
    quiet(4, 1'b0, F_0);

    @(negedge clk);
    #1;
    vec_cnt++;
    if (sb_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
